// File: rtl/cgia_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cgia_pkg
//  Description : Shared types, constants and helpers for the pixel packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cgia_pkg;

    localparam int DAT_W   = 16;
    localparam int COLOR_W = 8;

    typedef enum logic [2:0] {
        BPP_NONE = 3'd0,
        BPP1     = 3'd1,
        BPP2     = 3'd2,
        BPP4     = 3'd3,
        BPP8     = 3'd4
    } bpp_e;

    function automatic logic [4:0] ppw(input bpp_e bpp);
        case (bpp)
            BPP1:    ppw = 5'd16;
            BPP2:    ppw = 5'd8;
            BPP4:    ppw = 5'd4;
            BPP8:    ppw = 5'd2;
            default: ppw = 5'd0;
        endcase
    endfunction

    function automatic logic [3:0] bpp_bits(input bpp_e bpp);
        case (bpp)
            BPP1:    bpp_bits = 4'd1;
            BPP2:    bpp_bits = 4'd2;
            BPP4:    bpp_bits = 4'd4;
            BPP8:    bpp_bits = 4'd8;
            default: bpp_bits = 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pack_outbuf.sv
`default_nettype none
// ============================================================================
//  Module      : pack_outbuf
//  Description : 1-entry output register, or 2-entry FIFO when
//                PIXEL_PACKER_SKID_EN is defined; valid/ack on the read side.
//  Revision    : 1.0 - initial release
// ============================================================================
module pack_outbuf #(
    parameter int DAT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic [DAT_W-1:0] i_wr_data,
    input  logic             i_ack,
    output logic [DAT_W-1:0] o_data,
    output logic             o_valid,
    output logic             o_full
);
`ifdef PIXEL_PACKER_SKID_EN
    localparam int c_depth = 2;
`else
    localparam int c_depth = 1;
`endif

    generate
        if (c_depth == 2) begin : g_skid
            logic [DAT_W-1:0] r_data0;
            logic [DAT_W-1:0] r_data1;
            logic [1:0]       r_cnt;
            logic             w_pop;

            assign w_pop   = (r_cnt != 2'd0) & i_ack;
            assign o_data  = r_data0;
            assign o_valid = (r_cnt != 2'd0);
            assign o_full  = (r_cnt == 2'd2);

            // r_data0 is always the oldest word
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_data0 <= '0;
                    r_data1 <= '0;
                    r_cnt   <= 2'd0;
                end else begin
                    case ({i_wr, w_pop})
                        2'b10: begin
                            if (r_cnt == 2'd0) r_data0 <= i_wr_data;
                            else               r_data1 <= i_wr_data;
                            r_cnt <= r_cnt + 2'd1;
                        end
                        2'b01: begin
                            r_data0 <= r_data1;
                            r_cnt   <= r_cnt - 2'd1;
                        end
                        2'b11: begin
                            if (r_cnt == 2'd1) begin
                                r_data0 <= i_wr_data;
                            end else begin
                                r_data0 <= r_data1;
                                r_data1 <= i_wr_data;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end else begin : g_single
            logic [DAT_W-1:0] r_data;
            logic             r_valid;

            assign o_data  = r_data;
            assign o_valid = r_valid;
            assign o_full  = r_valid;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else if (i_wr) begin
                    r_data  <= i_wr_data;
                    r_valid <= 1'b1;
                end else if (r_valid & i_ack) begin
                    r_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_packer
//  Description : Packs colour indices MSB-first into 16-bit words at 1/2/4/8
//                bpp. PIXEL_PACKER_SKID_EN selects a 2-deep output FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_packer #(
    parameter int DAT_W   = 16,
    parameter int COLOR_W = 8
) (
    input  logic               dotclk_i,
    input  logic               reset_ni,
    input  logic               shift1_i,
    input  logic               shift2_i,
    input  logic               shift4_i,
    input  logic               shift8_i,
    input  logic [COLOR_W-1:0] index_xor_i,
    input  logic [COLOR_W-1:0] color_i,
    input  logic               color_valid_i,
    output logic               color_ready_o,
    input  logic               flush_i,
    output logic [DAT_W-1:0]   dat_o,
    output logic               dat_valid_o,
    input  logic               dat_ack_i,
    output logic [4:0]         fill_o
);
    import cgia_pkg::*;

    bpp_e               w_bpp;
    logic [3:0]         w_bits;
    logic [4:0]         w_n;
    logic [COLOR_W-1:0] w_mask;
    logic [COLOR_W-1:0] w_pix;
    logic [DAT_W-1:0]   w_acc_next;
    logic [DAT_W-1:0]   w_flush_data;
    logic [DAT_W-1:0]   w_wr_data;
    logic [7:0]         w_pad_sh;
    logic               w_mode_ok;
    logic               w_out_full;
    logic               w_accept;
    logic               w_last;
    logic               w_complete;
    logic               w_flush_wr;
    logic               w_wr;

    logic [DAT_W-1:0]   r_acc;
    logic [4:0]         r_fill;
    logic               r_flush_pend;

    always_comb begin
        w_bpp  = BPP_NONE;
        w_mask = '0;
        if (shift8_i) begin
            w_bpp  = BPP8;
            w_mask = 8'hFF;
        end else if (shift4_i) begin
            w_bpp  = BPP4;
            w_mask = 8'h0F;
        end else if (shift2_i) begin
            w_bpp  = BPP2;
            w_mask = 8'h03;
        end else if (shift1_i) begin
            w_bpp  = BPP1;
            w_mask = 8'h01;
        end
    end

    assign w_bits     = bpp_bits(w_bpp);
    assign w_n        = ppw(w_bpp);
    assign w_mode_ok  = (w_bpp != BPP_NONE);
    assign w_pix      = (color_i ^ index_xor_i) & w_mask;
    assign w_acc_next = (r_acc << w_bits) | DAT_W'(w_pix);
    assign w_last     = (r_fill == w_n - 5'd1);

    // Stall only when this pixel would finish a word with no slot to take it
    assign color_ready_o = w_mode_ok & ~r_flush_pend & ~(w_last & w_out_full & ~dat_ack_i);
    assign w_accept      = color_valid_i & color_ready_o;
    assign w_complete    = w_accept & w_last;

    // Left-justify the partial word so the first pixel still sits at bit 15
    assign w_pad_sh     = 8'd16 - ({3'b000, r_fill} * {4'b0000, w_bits});
    assign w_flush_data = r_acc << w_pad_sh;
    assign w_flush_wr   = r_flush_pend & (r_fill != 5'd0) & (~w_out_full | dat_ack_i);

    assign w_wr      = w_complete | w_flush_wr;
    assign w_wr_data = w_complete ? w_acc_next : w_flush_data;
    assign fill_o    = r_fill;

    always_ff @(posedge dotclk_i) begin
        if (!reset_ni) begin
            r_acc        <= '0;
            r_fill       <= 5'd0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc  <= w_acc_next;
                r_fill <= w_last ? 5'd0 : r_fill + 5'd1;
            end
            if (flush_i & w_mode_ok) begin
                r_flush_pend <= 1'b1;
            end
            if (r_flush_pend) begin
                if (r_fill == 5'd0) begin
                    r_flush_pend <= 1'b0;
                end else if (w_flush_wr) begin
                    r_fill       <= 5'd0;
                    r_flush_pend <= 1'b0;
                end
            end
        end
    end

    pack_outbuf #(
        .DAT_W (DAT_W)
    ) u_outbuf (
        .clk       (dotclk_i),
        .rst_n     (reset_ni),
        .i_wr      (w_wr),
        .i_wr_data (w_wr_data),
        .i_ack     (dat_ack_i),
        .o_data    (dat_o),
        .o_valid   (dat_valid_o),
        .o_full    (w_out_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_packer
//  Description : Directed self-checking bench for pixel_packer
//                (expectations follow PIXEL_PACKER_SKID_EN when defined).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_packer;

    logic        dotclk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        shift1_i = 1'b0;
    logic        shift2_i = 1'b0;
    logic        shift4_i = 1'b0;
    logic        shift8_i = 1'b0;
    logic [7:0]  index_xor_i = 8'h00;
    logic [7:0]  color_i = 8'h00;
    logic        color_valid_i = 1'b0;
    logic        color_ready_o;
    logic        flush_i = 1'b0;
    logic [15:0] dat_o;
    logic        dat_valid_o;
    logic        dat_ack_i = 1'b0;
    logic [4:0]  fill_o;

    int n_checks = 0;
    int n_errors = 0;

    pixel_packer dut (
        .dotclk_i      (dotclk_i),
        .reset_ni      (reset_ni),
        .shift1_i      (shift1_i),
        .shift2_i      (shift2_i),
        .shift4_i      (shift4_i),
        .shift8_i      (shift8_i),
        .index_xor_i   (index_xor_i),
        .color_i       (color_i),
        .color_valid_i (color_valid_i),
        .color_ready_o (color_ready_o),
        .flush_i       (flush_i),
        .dat_o         (dat_o),
        .dat_valid_o   (dat_valid_o),
        .dat_ack_i     (dat_ack_i),
        .fill_o        (fill_o)
    );

    always #5 dotclk_i = ~dotclk_i;

    task automatic tick;
        @(posedge dotclk_i);
        #1;
    endtask

    task automatic set_mode(input int bpp);
        shift1_i = (bpp == 1);
        shift2_i = (bpp == 2);
        shift4_i = (bpp == 4);
        shift8_i = (bpp == 8);
    endtask

    task automatic test_reset;
        reset_ni = 1'b0;
        set_mode(0);
        tick; tick;
        n_checks++;
        if (dat_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", dat_valid_o); end
        n_checks++;
        if (fill_o !== 5'd0) begin n_errors++; $display("FAIL reset_fill: got %0d expected 0", fill_o); end
        n_checks++;
        if (dat_o !== 16'h0000) begin n_errors++; $display("FAIL reset_dat: got %h expected 0000", dat_o); end
        n_checks++;
        if (color_ready_o !== 1'b0) begin n_errors++; $display("FAIL ready_no_mode: got %b expected 0", color_ready_o); end
        reset_ni = 1'b1;
        set_mode(1);
        #1;
        n_checks++;
        if (color_ready_o !== 1'b1) begin n_errors++; $display("FAIL ready_mode1: got %b expected 1", color_ready_o); end
        tick;
    endtask

    task automatic test_1bpp;
        set_mode(1);
        index_xor_i   = 8'h00;
        dat_ack_i     = 1'b1;
        color_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            color_i = (i % 2 == 0) ? 8'h01 : 8'h00;
            tick;
            if (i == 14) begin
                n_checks++;
                if (fill_o !== 5'd15 || dat_valid_o !== 1'b0) begin
                    n_errors++;
                    $display("FAIL 1bpp_fill15: got fill=%0d valid=%b expected fill=15 valid=0", fill_o, dat_valid_o);
                end
            end
        end
        color_valid_i = 1'b0;
        n_checks++;
        if (dat_valid_o !== 1'b1 || dat_o !== 16'hAAAA) begin
            n_errors++;
            $display("FAIL 1bpp_word: got valid=%b dat=%h expected valid=1 dat=aaaa", dat_valid_o, dat_o);
        end
        n_checks++;
        if (fill_o !== 5'd0) begin n_errors++; $display("FAIL 1bpp_fill0: got %0d expected 0", fill_o); end
        tick;
        n_checks++;
        if (dat_valid_o !== 1'b0) begin n_errors++; $display("FAIL 1bpp_drain: got %b expected 0", dat_valid_o); end
        dat_ack_i = 1'b0;
    endtask

    task automatic test_8bpp;
        logic [7:0] pix [4];
        logic       ready_ok;
        pix[0] = 8'h12; pix[1] = 8'h34; pix[2] = 8'h56; pix[3] = 8'h78;
        ready_ok = 1'b1;
        set_mode(8);
        dat_ack_i     = 1'b1;
        color_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            color_i = pix[i];
            #1;
            if (color_ready_o !== 1'b1) ready_ok = 1'b0;
            tick;
            if (i == 1) begin
                n_checks++;
                if (dat_valid_o !== 1'b1 || dat_o !== 16'h1234) begin
                    n_errors++;
                    $display("FAIL 8bpp_word1: got valid=%b dat=%h expected valid=1 dat=1234", dat_valid_o, dat_o);
                end
            end
        end
        color_valid_i = 1'b0;
        n_checks++;
        if (dat_valid_o !== 1'b1 || dat_o !== 16'h5678) begin
            n_errors++;
            $display("FAIL 8bpp_word2: got valid=%b dat=%h expected valid=1 dat=5678", dat_valid_o, dat_o);
        end
        n_checks++;
        if (ready_ok !== 1'b1) begin n_errors++; $display("FAIL 8bpp_ready: got drop=%b expected no drop", ~ready_ok); end
        tick;
        dat_ack_i = 1'b0;
    endtask

    task automatic test_4bpp_xor;
        set_mode(4);
        index_xor_i   = 8'h0F;
        dat_ack_i     = 1'b0;
        color_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            color_i = 8'(i);
            tick;
        end
        color_valid_i = 1'b0;
        n_checks++;
        if (dat_valid_o !== 1'b1 || dat_o !== 16'hFEDC) begin
            n_errors++;
            $display("FAIL 4bpp_xor: got valid=%b dat=%h expected valid=1 dat=fedc", dat_valid_o, dat_o);
        end
        dat_ack_i = 1'b1;
        tick;
        dat_ack_i   = 1'b0;
        index_xor_i = 8'h00;
    endtask

    task automatic test_flush;
        logic [7:0] pix [3];
        logic       seen;
        pix[0] = 8'h03; pix[1] = 8'h02; pix[2] = 8'h01;
        set_mode(2);
        dat_ack_i     = 1'b0;
        color_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            color_i = pix[i];
            tick;
        end
        color_valid_i = 1'b0;
        n_checks++;
        if (fill_o !== 5'd3 || dat_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_prefill: got fill=%0d valid=%b expected fill=3 valid=0", fill_o, dat_valid_o);
        end
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        #1;
        n_checks++;
        if (color_ready_o !== 1'b0) begin n_errors++; $display("FAIL flush_pend_ready: got %b expected 0", color_ready_o); end
        tick;
        n_checks++;
        if (dat_valid_o !== 1'b1 || dat_o !== 16'hE400 || fill_o !== 5'd0) begin
            n_errors++;
            $display("FAIL flush_word: got valid=%b dat=%h fill=%0d expected valid=1 dat=e400 fill=0", dat_valid_o, dat_o, fill_o);
        end
        n_checks++;
        if (color_ready_o !== 1'b1) begin n_errors++; $display("FAIL flush_ready_back: got %b expected 1", color_ready_o); end
        dat_ack_i = 1'b1;
        tick;
        seen = 1'b0;
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (dat_valid_o !== 1'b0) seen = 1'b1;
            tick;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_errors++; $display("FAIL flush_empty: got word=%b expected no word", seen); end
        n_checks++;
        if (color_ready_o !== 1'b1) begin n_errors++; $display("FAIL flush_empty_ready: got %b expected 1", color_ready_o); end
        dat_ack_i = 1'b0;
    endtask

    task automatic test_backpressure;
        set_mode(8);
        dat_ack_i     = 1'b0;
        color_valid_i = 1'b1;
        color_i = 8'hAA; tick;
        color_i = 8'hBB; tick;
        n_checks++;
        if (dat_valid_o !== 1'b1 || dat_o !== 16'hAABB) begin
            n_errors++;
            $display("FAIL bp_word1: got valid=%b dat=%h expected valid=1 dat=aabb", dat_valid_o, dat_o);
        end
        color_i = 8'hCC;
        #1;
        n_checks++;
        if (color_ready_o !== 1'b1) begin n_errors++; $display("FAIL bp_ready_cc: got %b expected 1", color_ready_o); end
        tick;
        n_checks++;
        if (fill_o !== 5'd1 || dat_o !== 16'hAABB) begin
            n_errors++;
            $display("FAIL bp_cc_taken: got fill=%0d dat=%h expected fill=1 dat=aabb", fill_o, dat_o);
        end
        color_i = 8'hDD;
        #1;
`ifdef PIXEL_PACKER_SKID_EN
        n_checks++;
        if (color_ready_o !== 1'b1) begin n_errors++; $display("FAIL bp_ready_dd: got %b expected 1", color_ready_o); end
        tick;
        color_valid_i = 1'b0;
        n_checks++;
        if (fill_o !== 5'd0 || dat_valid_o !== 1'b1 || dat_o !== 16'hAABB) begin
            n_errors++;
            $display("FAIL bp_skid_hold: got fill=%0d valid=%b dat=%h expected fill=0 valid=1 dat=aabb", fill_o, dat_valid_o, dat_o);
        end
        dat_ack_i = 1'b1;
        tick;
`else
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (color_ready_o !== 1'b0) begin n_errors++; $display("FAIL bp_stall: got ready=%b expected 0", color_ready_o); end
            tick;
        end
        n_checks++;
        if (fill_o !== 5'd1 || dat_o !== 16'hAABB) begin
            n_errors++;
            $display("FAIL bp_hold: got fill=%0d dat=%h expected fill=1 dat=aabb", fill_o, dat_o);
        end
        dat_ack_i = 1'b1;
        #1;
        n_checks++;
        if (color_ready_o !== 1'b1) begin n_errors++; $display("FAIL bp_ready_ack: got %b expected 1", color_ready_o); end
        tick;
        color_valid_i = 1'b0;
`endif
        n_checks++;
        if (dat_valid_o !== 1'b1 || dat_o !== 16'hCCDD || fill_o !== 5'd0) begin
            n_errors++;
            $display("FAIL bp_word2: got valid=%b dat=%h fill=%0d expected valid=1 dat=ccdd fill=0", dat_valid_o, dat_o, fill_o);
        end
        tick;
        n_checks++;
        if (dat_valid_o !== 1'b0) begin n_errors++; $display("FAIL bp_drain: got %b expected 0", dat_valid_o); end
        dat_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        set_mode(1);
        dat_ack_i     = 1'b0;
        color_valid_i = 1'b1;
        color_i       = 8'h01;
        for (int i = 0; i < 21; i++) tick;
        color_valid_i = 1'b0;
        n_checks++;
        if (fill_o !== 5'd5 || dat_valid_o !== 1'b1 || dat_o !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL rst_pre: got fill=%0d valid=%b dat=%h expected fill=5 valid=1 dat=ffff", fill_o, dat_valid_o, dat_o);
        end
        reset_ni = 1'b0;
        tick;
        reset_ni = 1'b1;
        n_checks++;
        if (fill_o !== 5'd0 || dat_valid_o !== 1'b0 || dat_o !== 16'h0000) begin
            n_errors++;
            $display("FAIL rst_mid: got fill=%0d valid=%b dat=%h expected fill=0 valid=0 dat=0000", fill_o, dat_valid_o, dat_o);
        end
    endtask

    initial begin
        test_reset;
        test_1bpp;
        test_8bpp;
        test_4bpp_xor;
        test_flush;
        test_backpressure;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
Inverse of the display-side pixel shifter. It accepts one colour index per dotclk and packs indices MSB-first into 16-bit words at 1, 2, 4 or 8 bpp. Completed words go to a memory-write/DMA client over a valid/ack handshake. The block sits on the capture/blit path; its words replay unchanged through the display shifter with the same mode and index_xor_i.

Parameters:
DAT_W, 16, packed word width; only 16 supported.
COLOR_W, 8, colour index width; only 8 supported.

Ports:
dotclk_i  in  1  sole clock, rising edge.
reset_ni  in  1  synchronous, active-low reset.
shift1_i  in  1  1 bpp mode select.
shift2_i  in  1  2 bpp mode select.
shift4_i  in  1  4 bpp mode select.
shift8_i  in  1  8 bpp mode select.
index_xor_i  in  8  XOR applied to each incoming index before packing.
color_i  in  8  colour index.
color_valid_i  in  1  color_i valid this cycle.
color_ready_o  out  1  packer accepts color_i this cycle.
flush_i  in  1  pulse: emit partial word, zero-padded.
dat_o  out  16  packed word.
dat_valid_o  out  1  dat_o valid; held until acked.
dat_ack_i  in  1  consumer takes dat_o this cycle.
fill_o  out  5  pixels currently in accumulator, 0..15.

Behaviour:
- Mode: priority shift8 > shift4 > shift2 > shift1 gives bpp B and pixels per word N = 16/B. With no select asserted, color_ready_o is 0 and flush is ignored. Mode must only change when fill_o = 0; a change mid-word is undefined.
- Accept: a pixel is taken when color_valid_i & color_ready_o. p = (color_i ^ index_xor_i) masked to its low B bits. Update acc <= (acc << B) | p and fill <= fill + 1. The first pixel ends in acc[15:16-B], matching the shifter reading q[15] first.
- Word complete: on the accept that makes fill = N, {acc<<B | p} is copied to the output register and fill wraps to 0. dat_valid_o rises the next cycle (1-cycle latency).
- Output register: one entry. Freed by dat_valid_o & dat_ack_i. Can be refilled in the same cycle it is freed.
- color_ready_o = mode_ok & ~flush_pend & ~(fill = N-1 & out_full & ~dat_ack_i). It stalls only when the next pixel would complete a word with nowhere to put it.
- Flush: flush_i sets flush_pend. If flush_i coincides with an accept, that pixel is packed first.
- Flush completion: while flush_pend is set and the output slot is free (or being acked), acc << ((N-fill)*B) is loaded to the output register. Then fill <= 0 and flush_pend clears.
- Empty flush: if fill = 0, flush_pend clears with no word emitted.
- Reset values: acc = 0, fill_o = 0, dat_o = 0, dat_valid_o = 0, flush_pend = 0. color_ready_o is then driven by mode.
- Reset mid-word discards partial data and any pending word.
- dat_o is stable while dat_valid_o & ~dat_ack_i. The consumer must not observe dat_o when dat_valid_o = 0.

Optional Feature:
PIXEL_PACKER_SKID_EN
- Defined: a second output entry forms a 2-deep FIFO, oldest word on dat_o.
- Stall condition becomes both entries full with the next pixel completing a word.
- Sustains one pixel per clock at 8 bpp with one-cycle ack gaps.
- Undefined: single output register as above.
- Reset clears both entries.

Decomposition:
- Shared package cgia_pkg:
  - bpp encoding enum (BPP1/2/4/8/NONE);
  - constants DAT_W and COLOR_W;
  - function ppw(bpp) returning pixels per word;
  - function bpp_bits(bpp).
- Natural sub-module pack_outbuf: 1- or 2-entry output buffer with valid/ack. The macro selects its depth.
- Mode decode and accumulator stay in pixel_packer.

Test Plan:
- 1 bpp, xor 0, 16 pixels alternating 1,0,… with continuous ack -> dat_o = 0xAAAA one cycle after the 16th accept; fill_o returns to 0.
- 8 bpp, pixels 0x12, 0x34, 0x56, 0x78 with ack held high -> two words 0x1234 then 0x5678; color_ready_o never drops.
- 4 bpp, index_xor_i = 0x0F, pixels 0, 1, 2, 3 -> 0xFEDC.
- 2 bpp, pixels 3, 2, 1 then flush_i -> single word 0xE400; flush at fill_o = 0 -> no word.
- 8 bpp, ack low, pixels 0xAA, 0xBB, 0xCC:
  - 0xAABB held on dat_o;
  - 0xCC accepted;
  - color_ready_o = 0 until ack (with PIXEL_PACKER_SKID_EN: stays 1 until 0xCCDD completes).
- Assert reset_ni = 0 for one cycle with fill_o = 5 and dat_valid_o = 1 -> next cycle dat_valid_o = 0, fill_o = 0, dat_o = 0.
